regfile_writeback: RTL

- Writer side of the 32x64 register file write port (rd / write_data / RegWrite, committed on posedge clk).
- Merges two result sources onto the single write port: the in-order pipeline (MEM/WB) and a late-return source (multi-cycle unit / late load).
- Holds late results in a small FIFO while the pipeline owns the port.
- Exports the registered write as a forwarding bus for the decode/execute bypass.

---
 rtl/regfile_writeback.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/regfile_writeback.sv
// Register-file write-port arbiter: merges in-order pipeline results with late-returning
// results (buffered in a small FIFO) and exports the registered write as a bypass bus.
module regfile_writeback #(
  parameter int XLEN   = 64,
  parameter int LDEPTH = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      pipe_valid,
  input  logic                      pipe_wen,
  input  logic [4:0]                pipe_rd,
  input  logic [1:0]                pipe_sel,
  input  logic [XLEN-1:0]           pipe_alu,
  input  logic [XLEN-1:0]           pipe_mem,
  input  logic [XLEN-1:0]           pipe_pc4,
  input  logic                      late_valid,
  input  logic [4:0]                late_rd,
  input  logic [XLEN-1:0]           late_data,
  output logic                      late_ready,
  output logic                      rf_we,
  output logic [4:0]                rf_rd,
  output logic [XLEN-1:0]           rf_wdata,
  output logic                      fwd_valid,
  output logic [4:0]                fwd_rd,
  output logic [XLEN-1:0]           fwd_data,
  output logic [$clog2(LDEPTH):0]   late_count
);

  localparam int PW = (LDEPTH > 1) ? $clog2(LDEPTH) : 1;
  localparam int CW = $clog2(LDEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(LDEPTH);

  logic [XLEN-1:0] fifo_data [LDEPTH];
  logic [4:0]      fifo_rd   [LDEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;

  logic            pipe_req_p0;
  logic            accept_p0;
  logic            late_take_p0;
  logic            fifo_empty_p0;
  logic            push_p0;
  logic            pop_p0;
  logic            issue_we_p0;
  logic [4:0]      issue_rd_p0;
  logic [XLEN-1:0] issue_data_p0;

  function automatic logic [XLEN-1:0] pipe_result(
    input logic [1:0]      sel,
    input logic [XLEN-1:0] alu,
    input logic [XLEN-1:0] mem,
    input logic [XLEN-1:0] pc4
  );
    logic [XLEN-1:0] r;
    case (sel)
      2'd0:    r = alu;
      2'd1:    r = mem;
      2'd2:    r = pc4;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Stage p0: request decode and port arbitration
  assign late_ready    = ~reset & (count < DEPTH_C);
  assign pipe_req_p0   = pipe_valid & pipe_wen & (pipe_rd != 5'd0);
  assign accept_p0     = late_valid & late_ready;
  // rd=0 late results are consumed here and never reach the FIFO or the port
  assign late_take_p0  = accept_p0 & (late_rd != 5'd0);
  assign fifo_empty_p0 = (count == '0);

  always_comb begin
    issue_we_p0   = 1'b0;
    issue_rd_p0   = '0;
    issue_data_p0 = '0;
    push_p0       = 1'b0;
    pop_p0        = 1'b0;
    if (pipe_req_p0) begin
      issue_we_p0   = 1'b1;
      issue_rd_p0   = pipe_rd;
      issue_data_p0 = pipe_result(pipe_sel, pipe_alu, pipe_mem, pipe_pc4);
      push_p0       = late_take_p0;
    end else if (!fifo_empty_p0) begin
      issue_we_p0   = 1'b1;
      issue_rd_p0   = fifo_rd[head];
      issue_data_p0 = fifo_data[head];
      pop_p0        = 1'b1;
      push_p0       = late_take_p0;
    end else if (late_take_p0) begin
      issue_we_p0   = 1'b1;
      issue_rd_p0   = late_rd;
      issue_data_p0 = late_data;
    end
  end

  always_ff @(posedge clk) begin
    if (push_p0) begin
      fifo_rd[tail]   <= late_rd;
      fifo_data[tail] <= late_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_p0) tail <= tail + 1'b1;
      if (pop_p0)  head <= head + 1'b1;
      case ({push_p0, pop_p0})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Stage p1: registered write port; rd/data hold when no write is issued
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we    <= 1'b0;
      rf_rd    <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= issue_we_p0;
      if (issue_we_p0) begin
        rf_rd    <= issue_rd_p0;
        rf_wdata <= issue_data_p0;
      end
    end
  end

  assign fwd_valid  = rf_we;
  assign fwd_rd     = rf_rd;
  assign fwd_data   = rf_wdata;
  assign late_count = count;

endmodule
